// File: rtl/fetch_pkg.sv
// Shared fetch-side types: FSM states, slot payload struct, and bus constants.
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_WAIT = 2'd1,
        ST_PUSH = 2'd2
    } fetch_state_t;

    localparam int          INST_W        = 64;
    localparam logic [31:0] DW_ALIGN_MASK = 32'hFFFF_FFF8;
    localparam int          INST_ERR_BIT  = 32;

    typedef struct packed {
        logic [31:0]       pc;
        logic [31:0]       npc;
        logic [INST_W-1:0] inst;
        logic              valid;
    } slot_t;

    // Instruction word in the low half, fault flag above it, rest zero.
    function automatic logic [INST_W-1:0] make_inst(input logic [31:0] word, input logic err);
        logic [INST_W-1:0] r;
        r               = '0;
        r[31:0]         = word;
        r[INST_ERR_BIT] = err;
        return r;
    endfunction

endpackage

// File: rtl/fetch_split.sv
// Combinational splitter: one fetched doubleword into up to two sequential slots.
// Zero latency; no flow control of its own.
module fetch_split
    import fetch_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [63:0] data,
    input  logic        err,
    output slot_t       slot1,
    output slot_t       slot2,
    output logic [31:0] next_pc
);

    always_comb begin
        slot1       = '0;
        slot2       = '0;
        next_pc     = pc + 32'd8;
        slot1.pc    = pc;
        slot1.npc   = pc + 32'd4;
        slot1.valid = 1'b1;
        if (!pc[2]) begin
            slot1.inst  = make_inst(data[31:0], err);
            slot2.pc    = pc + 32'd4;
            slot2.npc   = pc + 32'd8;
            slot2.inst  = make_inst(data[63:32], err);
            slot2.valid = 1'b1;
        end else begin
            // Entering mid-doubleword: only the upper word belongs to this fetch.
            slot1.inst = make_inst(data[63:32], err);
            next_pc    = pc + 32'd4;
        end
    end

endmodule

// File: rtl/fetch_dual.sv
// Dual-slot fetch: one doubleword request at a time, split into two IBU pushes.
// Latency: request + memory latency + one capture cycle; holds in PUSH while ibu_full.
module fetch_dual #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter int          INST_W   = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              is_flush,
    input  logic [31:0]       flush_pc,
    input  logic              ibu_full,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [31:0]       imem_req_addr,
    input  logic              imem_resp_valid,
    input  logic [63:0]       imem_resp_data,
    input  logic              imem_resp_err,
    output logic [31:0]       pc_out1,
    output logic [31:0]       npc_out1,
    output logic [INST_W-1:0] inst_out1,
    output logic              receive_flag1,
    output logic [31:0]       pc_out2,
    output logic [31:0]       npc_out2,
    output logic [INST_W-1:0] inst_out2,
    output logic              receive_flag2
);
    import fetch_pkg::*;

    fetch_state_t state;
    logic [31:0]  fetch_pc;
    logic [31:0]  next_pc_q;
    logic         drop;
    logic         req_vld_q;
    logic [31:0]  req_addr_q;
    slot_t        slot1_q;
    slot_t        slot2_q;

    slot_t        sp_slot1;
    slot_t        sp_slot2;
    logic [31:0]  sp_next_pc;
    logic [31:0]  flush_tgt;
    logic         hs;
    logic         push;

    fetch_split u_split (
        .pc      (fetch_pc),
        .data    (imem_resp_data),
        .err     (imem_resp_err),
        .slot1   (sp_slot1),
        .slot2   (sp_slot2),
        .next_pc (sp_next_pc)
    );

    assign flush_tgt = flush_pc & 32'hFFFF_FFFC;
    assign hs        = req_vld_q & imem_req_ready;
    assign push      = (state == ST_PUSH) & ~ibu_full & ~is_flush;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_REQ;
            fetch_pc   <= RESET_PC;
            next_pc_q  <= '0;
            drop       <= 1'b0;
            req_vld_q  <= 1'b0;
            req_addr_q <= '0;
            slot1_q    <= '0;
            slot2_q    <= '0;
        end else begin
            case (state)
                ST_REQ: begin
                    if (is_flush) begin
                        fetch_pc <= flush_tgt;
                        if (hs) begin
                            // Request already left: its response must be swallowed.
                            drop      <= 1'b1;
                            req_vld_q <= 1'b0;
                            state     <= ST_WAIT;
                        end else begin
                            req_vld_q  <= 1'b1;
                            req_addr_q <= flush_tgt & DW_ALIGN_MASK;
                        end
                    end else if (hs) begin
                        req_vld_q <= 1'b0;
                        state     <= ST_WAIT;
                    end else begin
                        req_vld_q  <= 1'b1;
                        req_addr_q <= fetch_pc & DW_ALIGN_MASK;
                    end
                end
                ST_WAIT: begin
                    if (is_flush) begin
                        fetch_pc <= flush_tgt;
                        if (imem_resp_valid) begin
                            drop       <= 1'b0;
                            state      <= ST_REQ;
                            req_vld_q  <= 1'b1;
                            req_addr_q <= flush_tgt & DW_ALIGN_MASK;
                        end else begin
                            drop <= 1'b1;
                        end
                    end else if (imem_resp_valid) begin
                        if (drop) begin
                            drop       <= 1'b0;
                            state      <= ST_REQ;
                            req_vld_q  <= 1'b1;
                            req_addr_q <= fetch_pc & DW_ALIGN_MASK;
                        end else begin
                            slot1_q   <= sp_slot1;
                            slot2_q   <= sp_slot2;
                            next_pc_q <= sp_next_pc;
                            state     <= ST_PUSH;
                        end
                    end
                end
                ST_PUSH: begin
                    if (is_flush) begin
                        fetch_pc   <= flush_tgt;
                        state      <= ST_REQ;
                        req_vld_q  <= 1'b1;
                        req_addr_q <= flush_tgt & DW_ALIGN_MASK;
                    end else if (!ibu_full) begin
                        fetch_pc   <= next_pc_q;
                        state      <= ST_REQ;
                        req_vld_q  <= 1'b1;
                        req_addr_q <= next_pc_q & DW_ALIGN_MASK;
                    end
                end
                default: begin
                    state     <= ST_REQ;
                    req_vld_q <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req_valid = req_vld_q;
    assign imem_req_addr  = req_addr_q;
    assign receive_flag1  = push & slot1_q.valid;
    assign receive_flag2  = push & slot2_q.valid;
    assign pc_out1        = slot1_q.pc;
    assign npc_out1       = slot1_q.npc;
    assign inst_out1      = slot1_q.inst;
    assign pc_out2        = slot2_q.pc;
    assign npc_out2       = slot2_q.npc;
    assign inst_out2      = slot2_q.inst;

endmodule

// File: tb/tb_fetch_dual.sv
// Scoreboard bench for fetch_dual: memory + IBU environment, event-level reference model.
module tb_fetch_dual;

    localparam logic [31:0] RST_PC = 32'h8000_0000;
    localparam logic [31:0] MASK   = 32'hFFFF_FFF8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        is_flush = 1'b0;
    logic [31:0] flush_pc = '0;
    logic        ibu_full = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid = 1'b0;
    logic [63:0] imem_resp_data = '0;
    logic        imem_resp_err = 1'b0;
    logic [31:0] pc_out1, npc_out1, pc_out2, npc_out2;
    logic [63:0] inst_out1, inst_out2;
    logic        receive_flag1, receive_flag2;

    fetch_dual dut (
        .clk             (clk),
        .rst             (rst),
        .is_flush        (is_flush),
        .flush_pc        (flush_pc),
        .ibu_full        (ibu_full),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .imem_resp_err   (imem_resp_err),
        .pc_out1         (pc_out1),
        .npc_out1        (npc_out1),
        .inst_out1       (inst_out1),
        .receive_flag1   (receive_flag1),
        .pc_out2         (pc_out2),
        .npc_out2        (npc_out2),
        .inst_out2       (inst_out2),
        .receive_flag2   (receive_flag2)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc1, npc1, pc2, npc2;
        logic [63:0] inst1, inst2;
        logic        v2;
    } exp_t;

    int checks = 0;
    int failures = 0;
    int push_cnt = 0;
    int cyc = 0;

    // Reference model state: program position and the single request in flight.
    logic [31:0] pc_m = RST_PC;
    logic        outstanding = 1'b0;
    logic        drop_m = 1'b0;
    logic        have_data = 1'b0;
    int          cap_cyc = 0;
    logic        push_now = 1'b0;
    logic [31:0] exp_req_q[$];
    exp_t        exp_push_q[$];

    logic mem_pend = 1'b0;
    int   mem_lat = 0;

    int          k_full_pct = 0, k_ready_pct = 100, k_lat_min = 0, k_lat_max = 0;
    int          k_err_pct = 0, k_flush_pm = 0;
    logic        k_fix_data = 1'b1;
    logic [63:0] k_data = 64'h00100093_00000013;
    logic        flush_req = 1'b0;
    logic [31:0] flush_tgt = '0;
    logic        stale_now = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] inst_of(input logic [31:0] w, input logic e);
        return {31'd0, e, w};
    endfunction

    function automatic exp_t expect_slots(input logic [31:0] pc, input logic [63:0] d, input logic e);
        exp_t x;
        x.pc1  = pc;
        x.npc1 = pc + 32'd4;
        if (pc[2] == 1'b0) begin
            x.inst1 = inst_of(d[31:0], e);
            x.v2    = 1'b1;
            x.pc2   = pc + 32'd4;
            x.npc2  = pc + 32'd8;
            x.inst2 = inst_of(d[63:32], e);
        end else begin
            x.inst1 = inst_of(d[63:32], e);
            x.v2    = 1'b0;
            x.pc2   = '0;
            x.npc2  = '0;
            x.inst2 = '0;
        end
        return x;
    endfunction

    // Apply what the coming clock edge does to the program-level model.
    task automatic model_step();
        logic        hs, rv;
        logic [31:0] tgt;
        hs = imem_req_valid && imem_req_ready;
        rv = imem_resp_valid;
        if (hs) begin
            mem_pend = 1'b1;
            mem_lat  = $urandom_range(k_lat_max, k_lat_min);
        end
        if (is_flush) begin
            tgt  = flush_pc & 32'hFFFF_FFFC;
            pc_m = tgt;
            if (have_data) begin
                have_data = 1'b0;
                exp_push_q.delete();
                exp_req_q.delete();
                exp_req_q.push_back(tgt & MASK);
            end else if (outstanding) begin
                if (rv) begin
                    outstanding = 1'b0;
                    drop_m      = 1'b0;
                    exp_req_q.delete();
                    exp_req_q.push_back(tgt & MASK);
                end else begin
                    drop_m = 1'b1;
                end
            end else if (hs) begin
                outstanding = 1'b1;
                drop_m      = 1'b1;
            end else begin
                exp_req_q.delete();
                exp_req_q.push_back(tgt & MASK);
            end
        end else if (have_data) begin
            if (!ibu_full) begin
                push_now  = 1'b1;
                pc_m      = pc_m + (pc_m[2] ? 32'd4 : 32'd8);
                have_data = 1'b0;
                exp_req_q.push_back(pc_m & MASK);
            end
        end else if (outstanding) begin
            if (rv) begin
                outstanding = 1'b0;
                if (drop_m) begin
                    drop_m = 1'b0;
                    exp_req_q.push_back(pc_m & MASK);
                end else begin
                    exp_push_q.push_back(expect_slots(pc_m, imem_resp_data, imem_resp_err));
                    have_data = 1'b1;
                    cap_cyc   = cyc;
                end
            end
        end else if (hs) begin
            outstanding = 1'b1;
        end
    endtask

    // Driver: IBU and memory environment, inputs change on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            ibu_full       = ($urandom_range(99) < k_full_pct);
            imem_req_ready = ($urandom_range(99) < k_ready_pct);
            flush_pc       = $urandom;
            is_flush       = 1'b0;
            if (flush_req) begin
                is_flush  = 1'b1;
                flush_pc  = flush_tgt;
                flush_req = 1'b0;
            end else if ($urandom_range(999) < k_flush_pm) begin
                is_flush = 1'b1;
                if ($urandom_range(7) == 0) flush_pc = 32'hFFFF_FFF0 | $urandom_range(15);
            end
            imem_resp_valid = 1'b0;
            imem_resp_err   = 1'b0;
            imem_resp_data  = {$urandom, $urandom};
            if (stale_now) begin
                imem_resp_valid = 1'b1;
                stale_now       = 1'b0;
            end else if (mem_pend) begin
                if (mem_lat == 0) begin
                    imem_resp_valid = 1'b1;
                    mem_pend        = 1'b0;
                end else begin
                    mem_lat--;
                end
            end
            if (imem_resp_valid) begin
                if (k_fix_data) imem_resp_data = k_data;
                imem_resp_err = ($urandom_range(99) < k_err_pct);
            end
            #1;
            push_now = 1'b0;
            if (rst) model_step();
        end
    end

    // Monitor: pops expectations whenever the DUT pushes or issues a request.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                if (receive_flag2 && !receive_flag1) chk("flag2_without_flag1", receive_flag2, 0);
                if (receive_flag1 !== push_now) chk("push_strobe", receive_flag1, push_now);
                if (receive_flag1) begin
                    if (exp_push_q.size() == 0) begin
                        chk("unexpected_push", receive_flag1, 0);
                    end else begin
                        e = exp_push_q.pop_front();
                        push_cnt++;
                        chk("pc1", pc_out1, e.pc1);
                        chk("npc1", npc_out1, e.npc1);
                        chk("inst1", inst_out1, e.inst1);
                        chk("flag2", receive_flag2, e.v2);
                        chk("pc2", pc_out2, e.pc2);
                        chk("npc2", npc_out2, e.npc2);
                        chk("inst2", inst_out2, e.inst2);
                    end
                end else if (have_data && cyc > cap_cyc && exp_push_q.size() > 0) begin
                    chk("stall_pc1", pc_out1, exp_push_q[0].pc1);
                    chk("stall_inst1", inst_out1, exp_push_q[0].inst1);
                    chk("stall_flag2", receive_flag2, 0);
                end
                if (imem_req_valid && imem_req_ready) begin
                    if (exp_req_q.size() == 0) chk("unexpected_request", imem_req_addr, 32'hFFFF_FFFF);
                    else chk("req_addr", imem_req_addr, exp_req_q.pop_front());
                end
            end
        end
    end

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_req_valid"}, imem_req_valid, 0);
        chk({tag, "_req_addr"}, imem_req_addr, 0);
        chk({tag, "_flags"}, {receive_flag1, receive_flag2}, 0);
        chk({tag, "_pcs"}, {pc_out1, pc_out2}, 0);
        chk({tag, "_npcs"}, {npc_out1, npc_out2}, 0);
        chk({tag, "_inst1"}, inst_out1, 0);
        chk({tag, "_inst2"}, inst_out2, 0);
    endtask

    task automatic model_reset();
        pc_m        = RST_PC;
        outstanding = 1'b0;
        drop_m      = 1'b0;
        have_data   = 1'b0;
        push_now    = 1'b0;
        mem_pend    = 1'b0;
        exp_push_q.delete();
        exp_req_q.delete();
        exp_req_q.push_back(RST_PC & MASK);
    endtask

    task automatic wait_pushes(input int target, input string name);
        int n = 0;
        while (push_cnt < target && n < 300) begin
            @(negedge clk);
            #3;
            n++;
        end
        chk(name, push_cnt >= target, 1);
    endtask

    task automatic wait_in_flight(input string name);
        int n = 0;
        while (!(outstanding && !drop_m) && n < 300) begin
            @(negedge clk);
            #3;
            n++;
        end
        chk(name, outstanding && !drop_m, 1);
    endtask

    task automatic wait_captured(input string name);
        int n = 0;
        while (!have_data && n < 300) begin
            @(negedge clk);
            #3;
            n++;
        end
        chk(name, have_data, 1);
    endtask

    task automatic flush_to(input logic [31:0] a);
        flush_tgt = a;
        flush_req = 1'b1;
    endtask

    initial begin
        int base;
        #1 rst = 1'b0;
        #2 chk_outputs_zero("reset");
        model_reset();
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;

        // Aligned fetch at reset PC with known data.
        wait_pushes(1, "first_push");
        k_fix_data = 1'b0;

        // Redirect into the upper word of a doubleword.
        @(negedge clk); #3;
        flush_to(32'h8000_0104);
        wait_pushes(push_cnt + 1, "unaligned_push");

        // IBU back-pressure held for several cycles.
        k_full_pct = 100;
        wait_captured("stall_capture");
        repeat (6) @(negedge clk);
        #3 k_full_pct = 0;
        wait_pushes(push_cnt + 1, "stall_release_push");

        // Redirect while the memory response is still pending.
        k_lat_min = 3;
        k_lat_max = 3;
        wait_in_flight("flush_wait_inflight");
        flush_to(32'h8000_0200);
        wait_pushes(push_cnt + 1, "after_wait_flush_push");

        // Access fault propagated on both slots.
        k_lat_min = 0;
        k_lat_max = 1;
        k_err_pct = 100;
        @(negedge clk); #3;
        flush_to(32'h8000_0300);
        wait_pushes(push_cnt + 2, "err_push");
        k_err_pct = 0;

        // Address arithmetic wraps at the top of the address space.
        @(negedge clk); #3;
        flush_to(32'hFFFF_FFF8);
        wait_pushes(push_cnt + 1, "wrap_push");

        // Reset mid-WAIT, then a stale response during REQ.
        k_lat_min = 3;
        k_lat_max = 3;
        wait_in_flight("reset_wait_inflight");
        @(posedge clk);
        #3 rst = 1'b0;
        #1 chk_outputs_zero("midreset");
        model_reset();
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        stale_now = 1'b1;
        wait_pushes(push_cnt + 1, "post_reset_push");

        // Randomized traffic.
        base        = push_cnt;
        k_lat_min   = 0;
        k_lat_max   = 3;
        k_full_pct  = 30;
        k_ready_pct = 60;
        k_err_pct   = 10;
        k_flush_pm  = 30;
        repeat (3000) @(negedge clk);
        #3;
        k_flush_pm = 0;
        k_full_pct = 0;
        repeat (30) @(negedge clk);
        #3 chk("random_push_progress", push_cnt > base + 100, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
